// File: rtl/reg_file_param_if.sv
// reg_file_param_if: operand/write-back/scoreboard bundle for reg_file_param.
//   Rs_ID, Rt_ID        read indices (A, B)
//   Rs_data_ID          read data A
//   Rt_data_ID          read data B after store masking
//   RegWrite, RegWr_ID  write enable and index
//   Write_data          raw write data
//   Load_size           extract size 00 word, 01 half, 10 byte, 11 word
//   Load_signed         1 = sign-extend the extracted field
//   Store_size          Rt masking size, same encoding as Load_size
//   Issue_load          load to Issue_ID enters the pipe
//   Issue_ID            destination index of the issued load
//   Stall               a read operand is pending
//   Busy_vec            per-register pending-load flags
// The slave modport is the register file; the master modport is the pipeline driving it.
interface reg_file_param_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [ADDR_W-1:0] Rs_ID;
    logic [ADDR_W-1:0] Rt_ID;
    logic [DATA_W-1:0] Rs_data_ID;
    logic [DATA_W-1:0] Rt_data_ID;
    logic              RegWrite;
    logic [ADDR_W-1:0] RegWr_ID;
    logic [DATA_W-1:0] Write_data;
    logic [1:0]        Load_size;
    logic              Load_signed;
    logic [1:0]        Store_size;
    logic              Issue_load;
    logic [ADDR_W-1:0] Issue_ID;
    logic              Stall;
    logic [NREGS-1:0]  Busy_vec;

    modport master (
        output Rs_ID, Rt_ID, RegWrite, RegWr_ID, Write_data, Load_size, Load_signed,
               Store_size, Issue_load, Issue_ID,
        input  Rs_data_ID, Rt_data_ID, Stall, Busy_vec
    );

    modport slave (
        input  Rs_ID, Rt_ID, RegWrite, RegWr_ID, Write_data, Load_size, Load_signed,
               Store_size, Issue_load, Issue_ID,
        output Rs_data_ID, Rt_data_ID, Stall, Busy_vec
    );
endinterface

// File: rtl/reg_file_param.sv
// reg_file_param: 2-read/1-write register file with load extension, write-to-read bypass,
// store masking on read port B and a per-register pending-load scoreboard.
//   clk    sole clock, rising edge active
//   rst_n  asynchronous active-low reset
//   bus    reg_file_param_if.slave (read ports, write port, scoreboard; see interface)
// Register 0 is hard-wired to zero and can never be marked busy.
module reg_file_param #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input logic              clk,
    input logic              rst_n,
    reg_file_param_if.slave  bus
);
    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [NREGS-1:0]  r_busy;

    logic [DATA_W-1:0] w_wv;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;
    logic [DATA_W-1:0] w_rt_masked;
    logic              w_rs_stall;
    logic              w_rt_stall;
    logic [NREGS-1:0]  w_set_vec;
    logic [NREGS-1:0]  w_clr_vec;
    logic [NREGS-1:0]  w_busy_d;

    // Effective write value: extract and extend per load size; word ignores Load_signed.
    always_comb begin
        w_wv = bus.Write_data;
        case (bus.Load_size)
            2'b10: w_wv = {{(DATA_W - 8){bus.Load_signed & bus.Write_data[7]}},
                           bus.Write_data[7:0]};
            2'b01: w_wv = {{(DATA_W - 16){bus.Load_signed & bus.Write_data[15]}},
                           bus.Write_data[15:0]};
            default: w_wv = bus.Write_data;
        endcase
    end

    assign w_wr_en = bus.RegWrite && (bus.RegWr_ID != '0);

    // r_regs[0] is never written, so it holds the reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[bus.RegWr_ID] <= w_wv;
        end
    end

    // Same-cycle bypass of the write value onto either read port.
    assign w_rs_val = (w_wr_en && (bus.RegWr_ID == bus.Rs_ID)) ? w_wv : r_regs[bus.Rs_ID];
    assign w_rt_val = (w_wr_en && (bus.RegWr_ID == bus.Rt_ID)) ? w_wv : r_regs[bus.Rt_ID];

    always_comb begin
        w_rt_masked = w_rt_val;
        case (bus.Store_size)
            2'b10: w_rt_masked = {{(DATA_W - 8){1'b0}}, w_rt_val[7:0]};
            2'b01: w_rt_masked = {{(DATA_W - 16){1'b0}}, w_rt_val[15:0]};
            default: w_rt_masked = w_rt_val;
        endcase
    end

    // Scoreboard: set beats clear on the same index; bit 0 is never set.
    assign w_set_vec = bus.Issue_load ? (NREGS'(1) << bus.Issue_ID) : '0;
    assign w_clr_vec = bus.RegWrite ? (NREGS'(1) << bus.RegWr_ID) : '0;
    assign w_busy_d  = (w_set_vec | (r_busy & ~w_clr_vec)) & ~NREGS'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_d;
        end
    end

    // A pending operand is released in the cycle its write-back arrives (bypass covers it).
    assign w_rs_stall = (bus.Rs_ID != '0) && r_busy[bus.Rs_ID] &&
                        !(bus.RegWrite && (bus.RegWr_ID == bus.Rs_ID));
    assign w_rt_stall = (bus.Rt_ID != '0) && r_busy[bus.Rt_ID] &&
                        !(bus.RegWrite && (bus.RegWr_ID == bus.Rt_ID));

    // Outputs are forced to zero while reset is held, even if a bypass is presented.
    assign bus.Rs_data_ID = rst_n ? w_rs_val : '0;
    assign bus.Rt_data_ID = rst_n ? w_rt_masked : '0;
    assign bus.Stall      = rst_n && (w_rs_stall || w_rt_stall);
    assign bus.Busy_vec   = r_busy;
endmodule
